// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard control unit: FSM states and the
// canned control-output patterns driven onto the pipeline enables.
package hazard_pkg;

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam logic [4:0] REG_X0     = 5'd0;
  localparam int         WAIT_CNT_W = 8;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_bubble;
    logic if_id_flush;
    logic ex_mem_hold;
  } ctrl_t;

  // Field order: pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_mem_hold
  localparam ctrl_t CTRL_RUN      = ctrl_t'(5'b11000);
  localparam ctrl_t CTRL_MEM_HOLD = ctrl_t'(5'b00001);
  localparam ctrl_t CTRL_FLUSH    = ctrl_t'(5'b11110);
  localparam ctrl_t CTRL_LOAD_USE = ctrl_t'(5'b00100);
  localparam ctrl_t CTRL_RESET    = ctrl_t'(5'b00110);

endpackage

// File: rtl/hazard_perf_counters.sv
// Free-running wrap-around event counters for load-use stalls, branch flushes
// and memory-wait stall cycles.
module hazard_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             loaduse_evt,
  input  logic             flush_evt,
  input  logic             memwait_evt,
  output logic [CNT_W-1:0] loaduse_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loaduse_cnt <= '0;
      flush_cnt   <= '0;
      memwait_cnt <= '0;
    end else begin
      if (loaduse_evt) loaduse_cnt <= loaduse_cnt + CNT_W'(1);
      if (flush_evt)   flush_cnt   <= flush_cnt + CNT_W'(1);
      if (memwait_evt) memwait_cnt <= memwait_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline sequencing controller: load-use bubbles, branch flushes and data-memory
// wait freezing with a timeout watchdog. Performance counters under HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic             ID_uses_rs1,
  input  logic             ID_uses_rs2,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_rd,
  input  logic             EX_branch_taken,
  input  logic             EX_MEM_MemAcc,
  input  logic             dmem_ready,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_Bubble,
  output logic             IF_ID_Flush,
  output logic             EX_MEM_Hold,
  output logic             mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_loaduse_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt,
  output logic [CNT_W-1:0] perf_memwait_cnt
`endif
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = WAIT_CNT_W'(MEM_WAIT_MAX);
  localparam logic [WAIT_CNT_W-1:0] WAIT_SAT = '1;

  state_t                state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  load_use;
  logic                  mem_stall;
  logic                  stall;
  logic                  rule_flush;
  logic                  rule_lu;
  ctrl_t                 ctrl;

  always_comb begin
    load_use   = ID_EX_MemRead && (ID_EX_rd != REG_X0) &&
                 ((ID_uses_rs1 && (ID_EX_rd == IF_ID_rs1)) ||
                  (ID_uses_rs2 && (ID_EX_rd == IF_ID_rs2)));
    mem_stall  = EX_MEM_MemAcc && !dmem_ready;
    // Once waiting, only dmem_ready releases the freeze; the MEM inputs are held anyway.
    stall      = (state == MEM_WAIT) ? !dmem_ready : mem_stall;
    rule_flush = !stall && EX_branch_taken;
    rule_lu    = !stall && !EX_branch_taken && load_use;

    ctrl = CTRL_RUN;
    if (!rst_n)          ctrl = CTRL_RESET;
    else if (stall)      ctrl = CTRL_MEM_HOLD;
    else if (rule_flush) ctrl = CTRL_FLUSH;
    else if (rule_lu)    ctrl = CTRL_LOAD_USE;
  end

  assign PCWrite      = ctrl.pc_write;
  assign IF_ID_Write  = ctrl.if_id_write;
  assign ID_EX_Bubble = ctrl.id_ex_bubble;
  assign IF_ID_Flush  = ctrl.if_id_flush;
  assign EX_MEM_Hold  = ctrl.ex_mem_hold;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else begin
            if (wait_cnt != WAIT_SAT) wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_MAX) mem_timeout <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .loaduse_evt (rule_lu),
    .flush_evt   (rule_flush),
    .memwait_evt (stall),
    .loaduse_cnt (perf_loaduse_cnt),
    .flush_cnt   (perf_flush_cnt),
    .memwait_cnt (perf_memwait_cnt)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed hazard scenarios followed by
// randomized traffic, all compared cycle by cycle against a rule-level reference model.
module tb_hazard_ctrl_unit;

  localparam int MAXW  = 4;
  localparam int CNT_W = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       uses1, uses2, memread, br, memacc, ready;
  logic       pcw, ifw, bub, flush, hold, tmo;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] c_lu, c_fl, c_mw;
`endif

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.MEM_WAIT_MAX(MAXW), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .IF_ID_rs1       (rs1),
    .IF_ID_rs2       (rs2),
    .ID_uses_rs1     (uses1),
    .ID_uses_rs2     (uses2),
    .ID_EX_MemRead   (memread),
    .ID_EX_rd        (rd),
    .EX_branch_taken (br),
    .EX_MEM_MemAcc   (memacc),
    .dmem_ready      (ready),
    .PCWrite         (pcw),
    .IF_ID_Write     (ifw),
    .ID_EX_Bubble    (bub),
    .IF_ID_Flush     (flush),
    .EX_MEM_Hold     (hold),
    .mem_timeout     (tmo)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_loaduse_cnt (c_lu),
    .perf_flush_cnt   (c_fl),
    .perf_memwait_cnt (c_mw)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: are we parked waiting on memory, how many waiting cycles so far,
  // the sticky timeout flag and the event tallies.
  bit m_wait;
  int m_waited;
  bit m_to;
  int m_lu, m_fl, m_mw;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    bit lu, st;
    int kind;
    int e_pcw, e_ifw, e_bub, e_fl, e_hold;
    @(negedge clk);
    lu = memread && (rd != 0) && ((uses1 && rd == rs1) || (uses2 && rd == rs2));
    st = m_wait ? !ready : (memacc && !ready);
    if (!rst_n)  kind = 0;
    else if (st) kind = 1;
    else if (br) kind = 2;
    else if (lu) kind = 3;
    else         kind = 4;
    case (kind)
      0:       begin e_pcw = 0; e_ifw = 0; e_bub = 1; e_fl = 1; e_hold = 0; end
      1:       begin e_pcw = 0; e_ifw = 0; e_bub = 0; e_fl = 0; e_hold = 1; end
      2:       begin e_pcw = 1; e_ifw = 0; e_bub = 1; e_fl = 1; e_hold = 0; end
      3:       begin e_pcw = 0; e_ifw = 0; e_bub = 1; e_fl = 0; e_hold = 0; end
      default: begin e_pcw = 1; e_ifw = 1; e_bub = 0; e_fl = 0; e_hold = 0; end
    endcase
    chk("PCWrite", int'(pcw), e_pcw);
    if (kind != 2) chk("IF_ID_Write", int'(ifw), e_ifw);
    chk("ID_EX_Bubble", int'(bub), e_bub);
    chk("IF_ID_Flush", int'(flush), e_fl);
    chk("EX_MEM_Hold", int'(hold), e_hold);
    chk("mem_timeout", int'(tmo), int'(m_to));
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_loaduse", int'(c_lu), m_lu);
    chk("perf_flush", int'(c_fl), m_fl);
    chk("perf_memwait", int'(c_mw), m_mw);
`endif
    @(posedge clk);
    if (!rst_n) begin
      m_wait = 0; m_waited = 0; m_to = 0;
      m_lu = 0; m_fl = 0; m_mw = 0;
    end else begin
      if (kind == 3) m_lu++;
      if (kind == 2) m_fl++;
      if (kind == 1) m_mw++;
      if (m_wait) begin
        if (ready) begin
          m_wait = 0; m_waited = 0;
        end else begin
          if (m_waited == MAXW) m_to = 1;
          if (m_waited < 255) m_waited++;
        end
      end else if (st) begin
        m_wait = 1;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3;
    uses1 = 1'b1; uses2 = 1'b1; memread = 1'b0; br = 1'b0;
    memacc = 1'b0; ready = 1'b1;
  endtask

  initial begin
    m_wait = 0; m_waited = 0; m_to = 0; m_lu = 0; m_fl = 0; m_mw = 0;
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Load-use on rs1, then the bubble has moved on
    memread = 1'b1; rd = 5'd5; rs1 = 5'd5;
    tick();
    memread = 1'b0;
    tick();

    // x0 destination and unused operand never stall
    memread = 1'b1; rd = 5'd0; rs1 = 5'd0;
    tick();
    rd = 5'd7; rs2 = 5'd7; rs1 = 5'd1; uses2 = 1'b0;
    tick();

    // Branch in the same cycle as a load-use
    uses2 = 1'b1;
    br = 1'b1;
    tick();
    idle_inputs();

    // Memory wait: three not-ready cycles, then release
    memacc = 1'b1; ready = 1'b0;
    repeat (3) tick();
    ready = 1'b1;
    tick();
    memacc = 1'b0;
    tick();

    // Timeout: never ready for a long stretch, release, flag stays
    memacc = 1'b1; ready = 1'b0;
    repeat (9) tick();
    ready = 1'b1;
    tick();
    memacc = 1'b0;
    tick(); tick();
    chk("timeout_sticky", int'(tmo), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("timeout_cleared", int'(tmo), 0);

    // Reset in the middle of a wait returns straight to RUN
    memacc = 1'b1; ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; memacc = 1'b0; ready = 1'b0;
    tick();
    idle_inputs();
    tick();

    // Randomized traffic with dense register matches
    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      rs1     = 5'($urandom_range(0, 3));
      rs2     = 5'($urandom_range(0, 3));
      rd      = 5'($urandom_range(0, 3));
      uses1   = 1'($urandom_range(0, 1));
      uses2   = 1'($urandom_range(0, 1));
      memread = ($urandom_range(0, 99) < 40);
      br      = ($urandom_range(0, 99) < 15);
      memacc  = ($urandom_range(0, 99) < 30);
      ready   = ($urandom_range(0, 99) < 45);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
